// File: rtl/dds_cmd_decoder_mc.sv
`default_nettype none
// ============================================================================
// Module   : dds_cmd_decoder_mc
// Brief    : Multi-channel DDS byte command decoder. Holds shadow/live tuning
//            words and per-channel enables, and answers each command with
//            ACK/NAK. Define DDS_READBACK_EN to add the READ (0x7) command.
// Revision : 1.0 - initial release
// ============================================================================
module dds_cmd_decoder_mc #(
    parameter int N_CH    = 4,
    parameter int M_WIDTH = 32,
    parameter int TIMEOUT = 12000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    received,
    input  logic [7:0]              rx_byte,
    input  logic                    tx_ready,
    output logic                    transmit,
    output logic [7:0]              tx_byte,
    output logic [N_CH*M_WIDTH-1:0] m,
    output logic [N_CH-1:0]         en,
    output logic [N_CH-1:0]         set,
    output logic                    error
);

    localparam int c_nb    = M_WIDTH / 8;
    localparam int c_sel_w = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [7:0] c_ack = 8'h06;
    localparam logic [7:0] c_nak = 8'h15;

    localparam logic [3:0] c_op_write   = 4'h1;
    localparam logic [3:0] c_op_select  = 4'h2;
    localparam logic [3:0] c_op_set     = 4'h3;
    localparam logic [3:0] c_op_enable  = 4'h4;
    localparam logic [3:0] c_op_disable = 4'h5;
    localparam logic [3:0] c_op_set_all = 4'h6;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_wait_data = 2'd1;
    localparam logic [1:0] c_st_resp      = 2'd2;
`ifdef DDS_READBACK_EN
    localparam logic [3:0] c_op_read      = 4'h7;
    localparam logic [1:0] c_st_read      = 2'd3;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [M_WIDTH-1:0] r_shadow [N_CH];
    logic [M_WIDTH-1:0] r_live   [N_CH];
    logic [N_CH-1:0]    r_en;
    logic [N_CH-1:0]    r_set;
    logic               r_error;
    logic               r_transmit;
    logic [7:0]         r_tx_byte;
    logic [c_sel_w-1:0] r_sel_ch;
    logic [3:0]         r_wr_idx;
    logic               r_nak;
    logic [c_cnt_w-1:0] r_cnt;

    logic [3:0] w_op;
    logic [3:0] w_arg;
    logic       w_legal;
    logic       w_exec;
    logic       w_go_write;
    logic       w_store;
    logic       w_resp_load;
    logic       w_resp_nak;
    logic       w_err;
    logic       w_tx;
    logic [7:0] w_tx_data;
`ifdef DDS_READBACK_EN
    logic [4:0] r_rd_idx;
    logic       w_rd_start;
    logic       w_rd_adv;
    logic [7:0] w_rd_byte;
`endif

    assign w_op  = rx_byte[7:4];
    assign w_arg = rx_byte[3:0];

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            c_op_write:   w_legal = (int'(w_arg) < c_nb);
            c_op_select:  w_legal = (int'(w_arg) < N_CH);
            c_op_set,
            c_op_enable,
            c_op_disable,
            c_op_set_all: w_legal = 1'b1;
`ifdef DDS_READBACK_EN
            c_op_read:    w_legal = 1'b1;
`endif
            default:      w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exec      = 1'b0;
        w_go_write  = 1'b0;
        w_store     = 1'b0;
        w_resp_load = 1'b0;
        w_resp_nak  = 1'b0;
        w_err       = 1'b0;
        w_tx        = 1'b0;
        w_tx_data   = 8'h00;
`ifdef DDS_READBACK_EN
        w_rd_start  = 1'b0;
        w_rd_adv    = 1'b0;
`endif
        case (r_state)
            c_st_idle: begin
                if (received) begin
                    if (!w_legal) begin
                        w_err       = 1'b1;
                        w_resp_load = 1'b1;
                        w_resp_nak  = 1'b1;
                        w_state_nxt = c_st_resp;
                    end else if (w_op == c_op_write) begin
                        w_go_write  = 1'b1;
                        w_state_nxt = c_st_wait_data;
`ifdef DDS_READBACK_EN
                    end else if (w_op == c_op_read) begin
                        w_rd_start  = 1'b1;
                        w_state_nxt = c_st_read;
`endif
                    end else begin
                        w_exec      = 1'b1;
                        w_resp_load = 1'b1;
                        w_state_nxt = c_st_resp;
                    end
                end
            end
            c_st_wait_data: begin
                // A byte arriving on the expiry cycle still counts as data.
                if (received) begin
                    w_store     = 1'b1;
                    w_resp_load = 1'b1;
                    w_state_nxt = c_st_resp;
                end else if (r_cnt == c_cnt_last) begin
                    w_err       = 1'b1;
                    w_resp_load = 1'b1;
                    w_resp_nak  = 1'b1;
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                w_err = received;
                if (tx_ready) begin
                    w_tx        = 1'b1;
                    w_tx_data   = r_nak ? c_nak : c_ack;
                    w_state_nxt = c_st_idle;
                end
            end
`ifdef DDS_READBACK_EN
            c_st_read: begin
                w_err = received;
                // Skip the cycle right after a strobe so each byte gets its own handshake.
                if (tx_ready && !r_transmit) begin
                    w_tx = 1'b1;
                    if (int'(r_rd_idx) == c_nb) begin
                        w_tx_data   = c_ack;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_tx_data = w_rd_byte;
                        w_rd_adv  = 1'b1;
                    end
                end
            end
`endif
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_shadow[c] <= '0;
                r_live[c]   <= '0;
            end
            r_en       <= '0;
            r_set      <= '0;
            r_error    <= 1'b0;
            r_transmit <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_sel_ch   <= '0;
            r_wr_idx   <= 4'h0;
            r_nak      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_set      <= '0;
            r_error    <= w_err;
            r_transmit <= w_tx;
            if (w_tx)        r_tx_byte <= w_tx_data;
            if (w_resp_load) r_nak     <= w_resp_nak;
            if (w_go_write)  r_wr_idx  <= w_arg;
            r_cnt <= (r_state == c_st_wait_data) ? r_cnt + 1'b1 : '0;
            if (w_store) begin
                for (int b = 0; b < c_nb; b++)
                    if (int'(r_wr_idx) == b) r_shadow[r_sel_ch][b*8 +: 8] <= rx_byte;
            end
            if (w_exec) begin
                case (w_op)
                    c_op_select:  r_sel_ch <= w_arg[c_sel_w-1:0];
                    c_op_set: begin
                        r_live[r_sel_ch] <= r_shadow[r_sel_ch];
                        r_set[r_sel_ch]  <= 1'b1;
                    end
                    c_op_enable:  r_en[r_sel_ch] <= 1'b1;
                    c_op_disable: r_en[r_sel_ch] <= 1'b0;
                    c_op_set_all: begin
                        for (int c = 0; c < N_CH; c++) r_live[c] <= r_shadow[c];
                        r_set <= '1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DDS_READBACK_EN
    always_comb begin
        w_rd_byte = 8'h00;
        for (int b = 0; b < c_nb; b++)
            if (int'(r_rd_idx) == b) w_rd_byte = r_live[r_sel_ch][b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)          r_rd_idx <= '0;
        else if (w_rd_start) r_rd_idx <= '0;
        else if (w_rd_adv)   r_rd_idx <= r_rd_idx + 1'b1;
    end
`endif

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_pack
            assign m[c*M_WIDTH +: M_WIDTH] = r_live[c];
        end
    endgenerate

    assign en       = r_en;
    assign set      = r_set;
    assign error    = r_error;
    assign transmit = r_transmit;
    assign tx_byte  = r_tx_byte;

endmodule
`default_nettype wire

// File: doc/dds_cmd_decoder_mc.md
Name: dds_cmd_decoder_mc

Overview:
- Multi-channel successor to the single-channel byte command decoder between the UART receiver/transmitter and the DDS phase accumulators.
- Decodes opcode/argument command bytes and keeps a shadow tuning word per channel.
- Commits shadow words atomically to the live outputs and drives per-channel enables.
- Returns ACK/NAK over the UART transmitter and aborts stalled transfers on an inter-byte timeout.

Parameters:
- N_CH, 4, number of DDS channels; 1..16.
- M_WIDTH, 32, tuning word width in bits; multiple of 8, 8..128.
- TIMEOUT, 12000, max cycles between command byte and data byte (1 ms at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- received  in  1  one-cycle strobe, rx_byte valid.
- rx_byte  in  8  received byte.
- tx_ready  in  1  UART transmitter idle, may accept a byte.
- transmit  out  1  one-cycle strobe, tx_byte valid.
- tx_byte  out  8  response byte.
- m  out  N_CH*M_WIDTH  live tuning words; channel c at [c*M_WIDTH +: M_WIDTH].
- en  out  N_CH  per-channel enable.
- set  out  N_CH  one-cycle commit pulse per channel.
- error  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst_n=0 at clk edge) values: m=0, shadows=0, en=0, set=0, error=0, transmit=0, tx_byte=0, sel_ch=0, state IDLE, timeout counter 0. Reset mid-transfer discards partial data and any pending response.
- Command byte: opcode = rx_byte[7:4], arg = rx_byte[3:0]. NB = M_WIDTH/8.
- 0x1 WRITE: arg = byte index k; legal when k<NB; go to WAIT_DATA; next byte goes to shadow[sel_ch][8k+:8].
- 0x2 SELECT: arg = channel; legal when arg<N_CH; sel_ch=arg.
- 0x3 SET: m[sel_ch]=shadow[sel_ch]; set[sel_ch]=1 for one cycle.
- 0x4 ENABLE: en[sel_ch]=1.
- 0x5 DISABLE: en[sel_ch]=0.
- 0x6 SET_ALL: all m=shadow in the same cycle; set=all ones for one cycle.
- Any other opcode, or an out-of-range arg, is illegal: error pulse and NAK; no state changes.
- States: IDLE, WAIT_DATA, RESP.
- IDLE: received -> decode. WRITE -> WAIT_DATA. Other legal -> RESP(ACK). Illegal -> RESP(NAK).
- WAIT_DATA: received -> store byte, RESP(ACK). Counter reaches TIMEOUT with no byte -> error pulse, RESP(NAK), shadow unchanged. Counter clears on entry.
- RESP: when tx_ready=1, transmit=1 for one cycle with tx_byte = 0x06 (ACK) or 0x15 (NAK), then IDLE. A received byte while in RESP is dropped, with an error pulse and no response.
- Latency: received at edge t -> m/en/set/error updated at t+1. Response transmit at t+2 at the earliest (enters RESP at t+1, fires on the first cycle with tx_ready=1).
- Simultaneous events:
  - received in the same cycle the timeout expires: the byte wins.
  - rst_n=0 overrides everything.
- Persistence: sel_ch and the shadows persist across commands; WRITE without a following SET never changes m.
- Output stability: set and error are single-cycle pulses; m changes only on SET/SET_ALL.

Optional Feature:
- Macro: DDS_READBACK_EN.
- Defined: opcode 0x7 READ is legal.
  - Transmits the NB bytes of m[sel_ch], LSB first, each on its own tx_ready handshake, followed by ACK.
  - Adds state READ with a byte counter.
  - Bytes received during READ are dropped with an error pulse.
- Undefined: 0x7 is illegal (error pulse + NAK), and no READ state logic is synthesised.

Test Plan:
- Load channel 2 with N_CH=4, M_WIDTH=32, tx_ready=1:
  - Stimulus: 0x22, 0x10,0x2A, 0x11,0x67, 0x12,0x02, 0x13,0x00, 0x30.
  - Response: m[2]=0x0002672A; set=4'b0100 for exactly one cycle; other channels stay 0; six ACK (0x06) strobes.
- Enable/disable: 0x21, 0x40 -> en=4'b0010; then 0x50 -> en=4'b0000; two ACKs per sequence.
- Illegal command:
  - 0x00 -> error pulse, tx_byte=0x15.
  - 0x25 with N_CH=4 -> NAK; sel_ch unchanged.
  - 0x14 with M_WIDTH=32 -> NAK.
- Timeout: 0x10, then no byte for TIMEOUT cycles -> error pulse, NAK, shadow unchanged. A later 0x30 leaves m unchanged.
- Backpressure and reset:
  - Hold tx_ready=0 after 0x40 -> transmit stays 0 and a byte received meanwhile gives an error pulse. Raise tx_ready -> one ACK.
  - rst_n=0 during WAIT_DATA -> all outputs return to reset values.
- DDS_READBACK_EN build: after loading channel 2, send 0x70 -> transmit sequence 0x2A, 0x67, 0x02, 0x00, 0x06. Same stimulus without the macro -> NAK.
